offset_cal_ctrl: RTL and testbench

OFFSET_CAL_CTRL -- requirements
Module: offset_cal_ctrl

---
 rtl/offset_cal_ctrl.sv | 143 ++++++++++++++
 tb/tb_offset_cal_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/offset_cal_ctrl.sv
// ADC offset calibration: discards a settle window, averages 2^log2_samples samples, drives -mean as the offset.
// Latency: busy for settle_cycles + 2^log2_samples + 1 clocks after an accepted start; manual offset 2 clocks from gpio0_i.
// Backpressure: none; start/manual are ignored while busy, abort is honoured in any busy state.
module offset_cal_ctrl #(
    parameter int data_width    = 16,
    parameter int log2_samples  = 10,
    parameter int settle_cycles = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [31:0]           gpio0_i,
    input  logic [data_width-1:0] adc_data_i,
    output logic [data_width-1:0] offset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           status_o
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_APPLY  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int acc_width = data_width + log2_samples;
    localparam int n_samples = 1 << log2_samples;
    localparam int cnt_max   = (settle_cycles > n_samples) ? settle_cycles : n_samples;
    localparam int cnt_width = $clog2(cnt_max) + 1;
    localparam logic [cnt_width-1:0]  settle_load = cnt_width'(settle_cycles - 1);
    localparam logic [cnt_width-1:0]  accum_load  = cnt_width'(n_samples - 1);
    localparam logic [data_width-1:0] min_val     = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0] max_val     = {1'b0, {(data_width-1){1'b1}}};

    state_t                      state_q, state_d;
    logic [31:0]                 cmd_q;
    logic                        start_qq;
    logic                        armed_q;
    logic                        start_ev;
    logic [cnt_width-1:0]        cnt_q, cnt_d;
    logic signed [acc_width-1:0] acc_q, acc_d, adc_ext;
    logic [data_width-1:0]       mean, offset_d, man_off;
    logic                        done_d, sat_q, sat_d, busy_d;
    logic [15:0]                 off16;
    logic                        unused_cmd_bits;

    // armed_q blocks a start that was already high when reset released.
    assign start_ev        = cmd_q[0] & ~start_qq & armed_q;
    assign adc_ext         = {{log2_samples{adc_data_i[data_width-1]}}, adc_data_i};
    assign mean            = data_width'(acc_q >>> log2_samples);
    assign man_off         = data_width'($signed(cmd_q[31:16]));
    assign off16           = 16'($signed(offset_o));
    assign unused_cmd_bits = ^cmd_q[15:3];
    assign status_o        = {off16, 10'd0, sat_q, done_o, busy_o, state_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        offset_d = offset_o;
        done_d   = done_o;
        sat_d    = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_q[1]) begin
                    offset_d = man_off;
                end else if (start_ev && !cmd_q[2]) begin
                    state_d = ST_SETTLE;
                    cnt_d   = settle_load;
                    acc_d   = '0;
                    done_d  = 1'b0;
                    sat_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cmd_q[2]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACCUM;
                    cnt_d   = accum_load;
                end else begin
                    cnt_d = cnt_q - cnt_width'(1);
                end
            end
            ST_ACCUM: begin
                if (cmd_q[2]) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_q + adc_ext;
                    if (cnt_q == '0) begin
                        state_d = ST_APPLY;
                    end else begin
                        cnt_d = cnt_q - cnt_width'(1);
                    end
                end
            end
            ST_APPLY: begin
                if (cmd_q[2]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    // The most negative mean has no positive twin in data_width bits.
                    if (mean == min_val) begin
                        offset_d = max_val;
                        sat_d    = 1'b1;
                    end else begin
                        offset_d = -mean;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM) || (state_d == ST_APPLY);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            start_qq <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            offset_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= gpio0_i;
            start_qq <= cmd_q[0];
            armed_q  <= armed_q | ~gpio0_i[0];
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            offset_o <= offset_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            sat_q    <= sat_d;
        end
    end
endmodule

// File: tb/tb_offset_cal_ctrl.sv
// Randomized bench for offset_cal_ctrl with a timeline/arithmetic reference model.
module tb_offset_cal_ctrl;
    localparam int DW = 16;
    localparam int L2 = 4;
    localparam int SC = 4;
    localparam int N  = 1 << L2;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] gpio0_i = '0;
    logic [15:0] adc_data_i = '0;
    logic [15:0] offset_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] status_o;

    int   checks = 0;
    int   errors = 0;
    logic [15:0] m_off  = '0;
    logic        m_done = 1'b0;
    logic        m_sat  = 1'b0;

    offset_cal_ctrl #(.data_width(DW), .log2_samples(L2), .settle_cycles(SC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .gpio0_i(gpio0_i), .adc_data_i(adc_data_i),
        .offset_o(offset_o), .busy_o(busy_o), .done_o(done_o), .status_o(status_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected state code after edge idx, where edge 0 is the first edge that sees start high on gpio.
    function automatic int exp_state(input int idx, input int abort_k);
        if (abort_k != 0 && idx >= abort_k) return 0;
        if (idx < 1)          return 0;
        if (idx <= SC)        return 1;
        if (idx <= SC + N)    return 2;
        if (idx == SC + N + 1) return 3;
        if (idx == SC + N + 2) return 4;
        return 0;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_offset"}, 32'(offset_o), 32'(m_off));
        chk({tag, "_busy"},   32'(busy_o), 32'(0));
        chk({tag, "_done"},   32'(done_o), 32'(m_done));
        chk({tag, "_status"}, status_o, {m_off, 10'd0, m_sat, m_done, 1'b0, 3'd0});
    endtask

    // mode: 0 random, 1 const -100, 2 +3/-4 with 0x7FFF settle, 3 const 0x8000, 4 zero, 5 random base + noise
    task automatic run_cal(input int mode, input int abort_k, input int man_k,
                           input logic [15:0] man_val, input int extra_k);
        logic signed [15:0] s [0:27];
        int   sum, mean, idx, st, base;
        logic [15:0] cal_off;
        logic cal_sat, e_busy, e_done, e_sat, prev_done, prev_sat;
        prev_done = m_done;
        prev_sat  = m_sat;
        base = int'($urandom_range(0, 40000)) - 20000;
        sum  = 0;
        for (int k = 0; k < 28; k++) begin
            case (mode)
                1: s[k] = -16'sd100;
                2: s[k] = (k <= SC + 1) ? 16'sh7FFF : (((k - SC) % 2 == 0) ? 16'sd3 : -16'sd4);
                3: s[k] = 16'sh8000;
                4: s[k] = 16'sd0;
                5: s[k] = 16'(base + int'($urandom_range(0, 30)) - 15);
                default: s[k] = 16'($urandom);
            endcase
            if (k >= SC + 2 && k <= SC + N + 1) sum += int'(s[k]);
        end
        mean    = (sum >= 0) ? sum / N : -((-sum + N - 1) / N);
        cal_sat = (mean == -32768);
        cal_off = cal_sat ? 16'h7FFF : 16'(-mean);

        for (int k = 0; k < 28; k++) begin
            @(negedge clk_i);
            if (k > 0) begin
                idx    = k - 1;
                st     = exp_state(idx, abort_k);
                e_busy = (st >= 1 && st <= 3);
                e_done = (idx == 0) ? prev_done : (abort_k == 0 && idx >= SC + N + 2);
                e_sat  = (idx == 0) ? prev_sat : ((abort_k == 0 && idx >= SC + N + 2) ? cal_sat : 1'b0);
                chk("busy", 32'(busy_o), 32'(e_busy));
                chk("status_lo", 32'(status_o[5:0]), 32'({e_sat, e_done, e_busy, 3'(st)}));
                if (abort_k == 0 && idx == SC + N + 2) begin
                    chk("cal_offset", 32'(offset_o), 32'(cal_off));
                    chk("cal_done", 32'(done_o), 32'(1));
                end
            end
            gpio0_i        = '0;
            gpio0_i[0]     = (k == 0) || (extra_k != 0 && k == extra_k);
            gpio0_i[1]     = (man_k != 0 && k >= man_k);
            gpio0_i[2]     = (abort_k != 0 && k == abort_k - 1);
            gpio0_i[31:16] = man_val;
            adc_data_i     = s[k];
        end
        if (abort_k == 0) begin
            m_off  = cal_off;
            m_done = 1'b1;
            m_sat  = cal_sat;
        end else begin
            m_done = 1'b0;
            m_sat  = 1'b0;
        end
        if (man_k != 0) m_off = man_val;
        chk_idle_outputs("end");
        gpio0_i = '0;
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #12;
        chk_idle_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        run_cal(1, 0, 0, 16'h0, 0);
        chk("const_m100", 32'(offset_o), 32'h0064);
        run_cal(2, 0, 0, 16'h0, 0);
        chk("alt_p3_m4", 32'(offset_o), 32'h0001);
        run_cal(3, 0, 0, 16'h0, 0);
        chk("sat_flag", 32'(status_o[5]), 32'(1));
        run_cal(4, 0, 0, 16'h0, 0);
        chk("zero_offset", 32'(offset_o), 32'h0000);

        // Manual load: two clocks from gpio, start ignored while manual
        @(negedge clk_i);
        gpio0_i = {16'h1234, 16'h0002};
        @(negedge clk_i);
        chk("manual_lat1", 32'(offset_o), 32'(m_off));
        @(negedge clk_i);
        chk("manual_lat2", 32'(offset_o), 32'h1234);
        m_off = 16'h1234;
        gpio0_i[0] = 1'b1;
        @(negedge clk_i);
        gpio0_i[0] = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            chk("manual_start_busy", 32'(busy_o), 32'(0));
        end
        gpio0_i = {16'h0010, 16'h0002};
        repeat (2) @(negedge clk_i);
        m_off = 16'h0010;
        gpio0_i = '0;
        repeat (2) @(negedge clk_i);
        chk_idle_outputs("manual_0010");

        // Abort seen on the 5th ACCUM edge
        run_cal(0, SC + 6, 0, 16'h0, 0);
        chk("abort_offset", 32'(offset_o), 32'h0010);

        run_cal(0, 0, 0, 16'h0, 0);
        run_cal(5, 0, 0, 16'h0, 7);
        run_cal(5, 0, 12, 16'hBEEF, 0);
        run_cal(0, 0, 0, 16'h0, 3);
        run_cal(5, 0, 0, 16'h0, 0);
        run_cal(5, SC + 2, 0, 16'h0, 0);
        run_cal(5, 0, 0, 16'h0, 15);

        // Reset mid-ACCUM with start held high across release
        @(negedge clk_i);
        gpio0_i = 32'h1;
        repeat (10) begin
            @(negedge clk_i);
            adc_data_i = 16'($urandom);
        end
        chk("pre_reset_busy", 32'(busy_o), 32'(1));
        #2 rstn_i = 1'b0;
        #1;
        m_off  = '0;
        m_done = 1'b0;
        m_sat  = 1'b0;
        chk_idle_outputs("async_reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            chk("held_start_busy", 32'(busy_o), 32'(0));
        end
        gpio0_i = '0;
        repeat (2) @(negedge clk_i);
        run_cal(5, 0, 0, 16'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
